// File: rtl/d_ff_pipe.sv
// rtl/d_ff_pipe.sv - WIDTH-bit, DEPTH-stage delay line with valid bits, stall, flush and occupancy count
module d_ff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [WIDTH*DEPTH-1:0]     taps,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_d;

  // Next state: flush clears everything, en shifts one stage, otherwise hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RST_VAL;
      end
      valid_d = '0;
      occ_d   = '0;
    end else if (en) begin
      data_d[0]  = d_in;
      valid_d[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // One word may enter and one may leave; the count stays within 0..DEPTH.
      occ_d = occ_q + OW'(d_valid) - OW'(valid_q[DEPTH-1]);
    end
  end

  // Stage registers and occupancy counter, cleared immediately when rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Raw stage contents exposed on the tap bus, stage i in slice i.
  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = valid_q[DEPTH-1];
  assign occ     = occ_q;

endmodule

// File: tb/tb_d_ff_pipe.sv
// tb/tb_d_ff_pipe.sv - scoreboard bench for d_ff_pipe at DEPTH 4, 1 and 7
module tb_d_ff_pipe;

  localparam logic [7:0] RV = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  d_in = 8'h00;
  logic        d_valid = 1'b0;

  logic [7:0]  q4, q1, q7;
  logic        qv4, qv1, qv7;
  logic [31:0] taps4;
  logic [7:0]  taps1;
  logic [55:0] taps7;
  logic [2:0]  occ4;
  logic [0:0]  occ1;
  logic [2:0]  occ7;

  int total = 0;
  int bad = 0;
  bit armed = 1'b0;

  typedef struct {
    int          id;
    logic [7:0]  q;
    logic        qv;
    int          occ;
    logic [63:0] taps;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Histories of words accepted since the last reset/flush, newest at the back, {data, valid}.
  logic [8:0] h4[$];
  logic [8:0] h1[$];
  logic [8:0] h7[$];

  d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(RV)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d_in(d_in), .d_valid(d_valid),
    .q(q4), .q_valid(qv4), .taps(taps4), .occ(occ4));
  d_ff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d_in(d_in), .d_valid(d_valid),
    .q(q1), .q_valid(qv1), .taps(taps1), .occ(occ1));
  d_ff_pipe #(.WIDTH(8), .DEPTH(7), .RST_VAL(RV)) u_d7 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d_in(d_in), .d_valid(d_valid),
    .q(q7), .q_valid(qv7), .taps(taps7), .occ(occ7));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stage i holds the i-th most recent accepted word, or the reset value if fewer were accepted.
  function automatic logic [8:0] stage_of(input logic [8:0] h[$], input int i);
    if (i < h.size()) return h[h.size()-1-i];
    return {RV, 1'b0};
  endfunction

  task automatic push_exp(input int id, input int depth, input logic [8:0] h[$]);
    exp_t e;
    logic [8:0] s;
    e.id = id;
    e.taps = '0;
    e.occ = 0;
    for (int i = 0; i < depth; i++) begin
      s = stage_of(h, i);
      e.taps[i*8 +: 8] = s[8:1];
    end
    foreach (h[k]) if (h[k][0]) e.occ++;
    s = stage_of(h, depth-1);
    e.q = s[8:1];
    e.qv = s[0];
    exp_q.push_back(e);
  endtask

  task automatic clear_hist();
    h4.delete();
    h1.delete();
    h7.delete();
  endtask

  task automatic cycle(input logic r, input logic e, input logic f, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; flush = f; d_valid = v; d_in = d;
    if (!r || f) begin
      clear_hist();
    end else if (e) begin
      h4.push_back({d, v}); while (h4.size() > 4) void'(h4.pop_front());
      h1.push_back({d, v}); while (h1.size() > 1) void'(h1.pop_front());
      h7.push_back({d, v}); while (h7.size() > 7) void'(h7.pop_front());
    end
    push_exp(0, 4, h4);
    push_exp(1, 1, h1);
    push_exp(2, 7, h7);
    armed = 1'b1;
  endtask

  // Monitor: after every rising edge, pop one expectation per pipeline and compare.
  always begin
    @(posedge clk);
    #1;
    if (armed) begin
      for (int n = 0; n < 3; n++) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 64'd0, 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          case (mon_e.id)
            0: begin
              chk("d4_q", 64'(q4), 64'(mon_e.q));
              chk("d4_q_valid", 64'(qv4), 64'(mon_e.qv));
              chk("d4_occ", 64'(occ4), 64'(mon_e.occ));
              chk("d4_taps", 64'(taps4), mon_e.taps);
            end
            1: begin
              chk("d1_q", 64'(q1), 64'(mon_e.q));
              chk("d1_q_valid", 64'(qv1), 64'(mon_e.qv));
              chk("d1_occ", 64'(occ1), 64'(mon_e.occ));
              chk("d1_taps", 64'(taps1), mon_e.taps);
            end
            default: begin
              chk("d7_q", 64'(q7), 64'(mon_e.q));
              chk("d7_q_valid", 64'(qv7), 64'(mon_e.qv));
              chk("d7_occ", 64'(occ7), 64'(mon_e.occ));
              chk("d7_taps", 64'(taps7), mon_e.taps);
            end
          endcase
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tmp;
    // Reset held across edges.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h3D);
    // Latency: 01..08 streamed with en held high, then drained.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'(i));
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // Stall: fill 11..14, hold three cycles with toggling d_in, then resume.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h11 + 8'(i));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 8'hFF : 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // Bubbles: C0..C3 with valid pattern 1,0,1,0.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, (i % 2 == 0), 8'hC0 + 8'(i));
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // Flush collision: full pipeline, flush with en and a valid FF on the same edge.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h50 + 8'(i));
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // Asynchronous reset mid-cycle on a loaded pipeline.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h60 + 8'(i));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_q", 64'(q4), 64'(RV));
    chk("async_q_valid", 64'(qv4), 64'd0);
    chk("async_occ", 64'(occ4), 64'd0);
    chk("async_taps", 64'(taps4), 64'({4{RV}}));
    chk("async_d7_q", 64'(q7), 64'(RV));
    chk("async_d1_occ", 64'(occ1), 64'd0);
    clear_hist();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
    // Random run with occasional flushes and reset pulses.
    for (int i = 0; i < 500; i++) begin
      tmp = 8'($urandom_range(0, 255));
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), tmp);
    end
    @(posedge clk);
    #2;
    armed = 1'b0;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_ff_pipe.md
# d_ff_pipe

Parametrised register pipeline that extends the single-bit D flip-flop to a WIDTH-bit, DEPTH-stage delay line. Each stage carries a valid bit, and the pipeline supports a global advance enable (stall) and a synchronous flush. A registered occupancy count and a per-stage tap bus are also provided. It is used wherever a data path must be retimed by a fixed number of cycles with stall and flush control.

## Interface
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of register stages, i.e. latency (>=1)
- RST_VAL, 0, WIDTH-bit value loaded into every data stage on reset and on flush
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous assert, active-low; all state cleared while low
- en  input  1  advance enable; 1 = pipeline shifts one stage this edge, 0 = hold
- flush  input  1  synchronous flush; highest priority after reset
- d_in  input  WIDTH  data into stage 0
- d_valid  input  1  valid qualifier for d_in
- q  output  WIDTH  data of stage DEPTH-1
- q_valid  output  1  valid bit of stage DEPTH-1
- taps  output  WIDTH*DEPTH  all stage data; stage i at bits [i*WIDTH +: WIDTH]
- occ  output  $clog2(DEPTH+1)  number of stages whose valid bit is 1

## Operation
- Per-edge priority (rst high): flush > en > hold.
- rst low: every stage data = RST_VAL, every valid = 0, occ = 0. Takes effect immediately and does not wait for clk. Held for as long as rst is low.
- flush=1: every stage data = RST_VAL, every valid = 0, occ = 0. d_in/d_valid on that edge are discarded, regardless of en.
- en=1, flush=0: stage0 <= {d_in, d_valid}; stage i <= stage i-1 for i = 1..DEPTH-1. The old last stage is dropped.
- en=0, flush=0: all stages, valids and occ hold. d_in is ignored.
- Data is moved regardless of its valid bit. Invalid stages still shift their (don't-care) data, so taps show raw stage contents.
- occ is a registered counter, not a popcount. On a shift, occ_next = occ + d_valid - q_valid. It stays in 0..DEPTH under every input sequence. The verifier checks occ == popcount(valids) every cycle.
- DEPTH=1: a single stage, q = taps, and occ is 1 bit.
- No combinational path from any input to any output.

## Timing
- Latency: a word presented with en=1 at edge n appears on q/q_valid after edge n+DEPTH-1, i.e. it is visible for the cycle following DEPTH enabled edges.
- Stalls stretch the latency: a word exits after exactly DEPTH enabled edges, however many en=0 cycles intervene.
- All outputs change only on a rising clk edge or on rst assertion.
- Reset values: q = RST_VAL, q_valid = 0, taps = {DEPTH{RST_VAL}}, occ = 0.
- Reset mid-operation: in-flight words are lost, and the outputs show reset values within the same cycle that rst falls.
- The first edge after rst rises behaves as a normal edge. Release synchronisation is the system's responsibility.
- flush and en asserted on the same edge: the flush result applies, with nothing loaded.
- occ saturation: with the pipeline full (occ = DEPTH), en=1 and d_valid=1 shifts a valid word out and a valid word in, so occ stays at DEPTH.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RST_VAL=8'hA5, rst low mid-cycle -> q=8'hA5, q_valid=0, occ=0, all taps 8'hA5 immediately, without a clk edge.
- Latency: en=1 constant, feed 8'h01..8'h08 with d_valid=1 -> 8'h01 on q with q_valid=1 after the 4th edge, then one word per cycle in order, with occ going 1,2,3,4,4,4.
- Stall: fill with 8'h11..8'h14, then en=0 for 3 cycles while d_in toggles -> q, taps and occ unchanged. After en returns, 8'h11 exits on the next edge.
- Bubbles: en=1, d_valid pattern 1,0,1,0 with data 8'hC0..8'hC3 -> q_valid pattern 1,0,1,0 on q after latency 4, with occ peaking at 2.
- Flush collision: full pipeline, flush=1 with en=1 and d_valid=1, d_in=8'hFF -> next cycle all valids 0, occ=0, taps = RST_VAL, and 8'hFF never appears on q.
- Random run: 500 cycles of random en/flush/d_valid/d_in with rst pulses, DEPTH=1 and DEPTH=7 -> q matches a reference queue model, and occ equals popcount(valids) every cycle.
